// File: rtl/counter_share_ctrl_if.sv
// Bundle between requester blocks, the shared counter unit and the
// counter_share_ctrl scheduler.
//   req     requester -> ctrl  per-requester request level
//   len     requester -> ctrl  per-requester delay, requester i at len[i*N +: N]
//   gnt     ctrl -> requester  one-hot grant
//   done    ctrl -> requester  one-cycle completion pulse
//   busy    ctrl -> system     scheduler not idle
//   cnt_ld  ctrl -> counter    load strobe
//   cnt_in  ctrl -> counter    load value
//   cnt_en  ctrl -> counter    increment enable
//   cnt_clr ctrl -> counter    synchronous clear
//   cnt_ov  counter -> ctrl    counter is all ones
// The slave modport is the scheduler's view; master is the environment's.
interface counter_share_ctrl_if #(
  parameter int unsigned N    = 5,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] len;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              cnt_ld;
  logic [N-1:0]      cnt_in;
  logic              cnt_en;
  logic              cnt_clr;
  logic              cnt_ov;

  modport master (
    output req, len, cnt_ov,
    input  gnt, done, busy, cnt_ld, cnt_in, cnt_en, cnt_clr
  );

  modport slave (
    input  req, len, cnt_ov,
    output gnt, done, busy, cnt_ld, cnt_in, cnt_en, cnt_clr
  );
endinterface

// File: rtl/counter_share_ctrl.sv
// Round-robin scheduler time-sharing one N-bit counter among NREQ requesters.
// A granted requester asking for L cycles gets its counter loaded with ~L;
// the counter then counts up to all ones, which takes exactly L increments.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    counter_share_ctrl_if.slave (req/len/gnt/done/busy and counter controls)
module counter_share_ctrl #(
  parameter int unsigned N    = 5,
  parameter int unsigned NREQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  counter_share_ctrl_if.slave bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_q, gnt_nxt;
  logic [PW-1:0]   gidx_q, gidx_nxt;
  logic [PW-1:0]   rr_q, rr_nxt;
  logic [PW-1:0]   gidx_inc;
  logic [PW-1:0]   cand, sel_idx;
  logic            sel_found;
  logic            abort;
  logic            cnt_ld, cnt_en, cnt_clr;
  logic [N-1:0]    len_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_arr[i] = bus.len[i*N +: N];
  end

  // Explicit wrap so non-power-of-two NREQ also works.
  assign gidx_inc = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

  // Granted requester withdrew its request.
  assign abort = ~|(bus.req & gnt_q);

  // First requesting index at or after the round-robin pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(rr_q) + k) % NREQ);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    gidx_nxt  = gidx_q;
    rr_nxt    = rr_q;
    cnt_clr   = 1'b0;
    cnt_ld    = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (sel_found) begin
          gnt_nxt          = '0;
          gnt_nxt[sel_idx] = 1'b1;
          gidx_nxt         = sel_idx;
          state_nxt        = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_ld = 1'b1;
        if (abort) begin
          gnt_nxt   = '0;
          rr_nxt    = gidx_inc;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cnt_en = ~bus.cnt_ov;
        // Abort takes priority over a simultaneous overflow: no done pulse.
        if (abort) begin
          gnt_nxt   = '0;
          rr_nxt    = gidx_inc;
          state_nxt = S_IDLE;
        end else if (bus.cnt_ov) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        gnt_nxt   = '0;
        rr_nxt    = gidx_inc;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      gnt_q  <= '0;
      gidx_q <= '0;
      rr_q   <= '0;
    end else begin
      state  <= state_nxt;
      gnt_q  <= gnt_nxt;
      gidx_q <= gidx_nxt;
      rr_q   <= rr_nxt;
    end
  end

  // gnt is still held in DONE, so it doubles as the done vector there.
  assign bus.gnt     = gnt_q;
  assign bus.done    = (state == S_DONE) ? gnt_q : '0;
  assign bus.busy    = (state != S_IDLE);
  assign bus.cnt_ld  = cnt_ld;
  assign bus.cnt_en  = cnt_en;
  assign bus.cnt_clr = cnt_clr;
  assign bus.cnt_in  = ~len_arr[gidx_q];
endmodule

// File: tb/tb_counter_share_ctrl.sv
module tb_counter_share_ctrl;
  localparam int unsigned N    = 5;
  localparam int unsigned NREQ = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  counter_share_ctrl_if #(.N(N), .NREQ(NREQ)) bus ();

  counter_share_ctrl #(.N(N), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter unit.
  logic [N-1:0] cnt = '0;
  always @(posedge clk) begin
    if (bus.cnt_clr)     cnt <= '0;
    else if (bus.cnt_ld) cnt <= bus.cnt_in;
    else if (bus.cnt_en) cnt <= cnt + 1'b1;
  end
  assign bus.cnt_ov = &cnt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level reference: a grant sampled at cycle t0 for length L
  // yields LOAD at t0+1, counting on t0+2..t0+L+1, done at t0+L+3,
  // unless the requester drops first.
  int              cyc = 0;
  bit              m_active = 0;
  int              m_g, m_t0, m_L, off;
  int              m_rr = 0;
  logic [NREQ-1:0] e_gnt, e_done;
  logic            e_busy, e_clr, e_ld, e_en;
  logic [N-1:0]    e_cin;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_rr     = 0;
    end else begin
      if (!m_active) begin
        e_gnt = '0; e_done = '0; e_busy = 0; e_clr = 1; e_ld = 0; e_en = 0;
      end else begin
        off = cyc - m_t0;
        e_gnt = '0;
        e_gnt[m_g] = 1'b1;
        e_busy = 1; e_clr = 0;
        e_ld   = (off == 1);
        e_en   = (off >= 2 && off < m_L + 2);
        e_done = (off == m_L + 3) ? e_gnt : '0;
        e_cin  = ~(N'(m_L));
        chk("m_cnt_in", bus.cnt_in, e_cin);
        if (off >= 2 && off <= m_L + 2) chk("m_cnt_ov", bus.cnt_ov, off == m_L + 2);
      end
      chk("m_gnt", bus.gnt, e_gnt);
      chk("m_done", bus.done, e_done);
      chk("m_busy", bus.busy, e_busy);
      chk("m_cnt_clr", bus.cnt_clr, e_clr);
      chk("m_cnt_ld", bus.cnt_ld, e_ld);
      chk("m_cnt_en", bus.cnt_en, e_en);
      if (!m_active) begin
        if (|bus.req) begin
          for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req[(m_rr + k) % NREQ]) m_g = (m_rr + k) % NREQ;
          m_active = 1;
          m_t0     = cyc;
          m_L      = int'(bus.len[m_g*N +: N]);
        end
      end else if (off == m_L + 3 || !bus.req[m_g]) begin
        m_active = 0;
        m_rr     = (m_g + 1) % NREQ;
      end
      cyc++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_single(input int g, input int L, input int exp_done,
                            input int exp_en, input logic [N-1:0] exp_cin);
    int ld_off, done_off, en_cnt;
    @(posedge clk); #1;
    bus.len[g*N +: N] = N'(L);
    bus.req[g] = 1'b1;
    ld_off = -1; done_off = -1; en_cnt = 0;
    for (int k = 0; k < 60 && done_off < 0; k++) begin
      @(negedge clk);
      if (bus.cnt_ld && ld_off < 0) begin
        ld_off = k;
        chk("single_cnt_in", bus.cnt_in, exp_cin);
      end
      if (bus.cnt_en) en_cnt++;
      if (bus.done != '0) begin
        done_off = k;
        chk("single_done_vec", bus.done, 32'(1) << g);
      end
    end
    chk("single_ld_time", ld_off, 1);
    chk("single_done_time", done_off, exp_done);
    chk("single_en_cycles", en_cnt, exp_en);
    @(posedge clk); #1 bus.req[g] = 1'b0;
    @(negedge clk);
    chk("single_done_width", bus.done, 0);
  endtask

  function automatic logic [N-1:0] rand_len();
    if ($urandom_range(0, 9) == 0) return '1;
    return N'($urandom_range(0, 6));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [NREQ-1:0] exp_order [5];
  logic [NREQ-1:0] d;
  int              n, first_done, done_k;

  initial begin
    rst_n   = 1'b0;
    bus.req = '0;
    bus.len = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed single requests with hand-computed latencies.
    run_single(0, 5, 8, 5, 5'b11010);
    run_single(2, 0, 3, 0, 5'b11111);
    run_single(3, 31, 34, 31, 5'b00000);

    // Asynchronous reset in the middle of a RUN.
    @(posedge clk); #1;
    bus.len[0 +: N] = N'(20);
    bus.req = 4'b0001;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    bus.req = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_clr", bus.cnt_clr, 1);

    // Abort three cycles into RUN; pointer must move past requester 1.
    @(posedge clk); #1;
    bus.len[1*N +: N] = N'(10);
    bus.len[2*N +: N] = N'(2);
    bus.len[0 +: N]   = N'(3);
    bus.req = 4'b0010;
    first_done = -1; done_k = -1;
    for (int k = 0; k < 30 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 5) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_clr", bus.cnt_clr, 1);
      end
      if (k == 6) chk("abort_next_gnt", bus.gnt, 4'b0100);
      if (bus.done != '0) begin
        done_k = k;
        chk("abort_first_done", bus.done, 4'b0100);
      end
      if (k == 3) begin
        @(posedge clk); #1 bus.req = 4'b0101;
      end
    end
    chk("abort_done_time", done_k, 10);
    @(posedge clk); #1 bus.req = '0;

    // Round robin with all four requesting, len=1 each.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) bus.len[i*N +: N] = N'(1);
    bus.req = '1;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n = 0;
    for (int k = 0; k < 60 && n < 5; k++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        chk("rr_order", bus.done, exp_order[n]);
        chk("rr_time", k, 4 + 5 * n);
        n++;
      end
    end
    chk("rr_count", n, 5);
    @(posedge clk); #1 bus.req = '0;

    // Randomized traffic checked by the reference model.
    for (int cy = 0; cy < 3000; cy++) begin
      @(negedge clk);
      d = bus.done;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.len[i*N +: N] = rand_len();
            bus.req[i] = 1'b1;
          end
        end else if (d[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
    bus.req = '0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
